// File: rtl/fft_pkg.sv
// Shared FFT front-end types and widths: sample width, frame size, loader FSM states.
// Also holds the index bit-reversal helper used to reorder a loaded frame.
package fft_pkg;

  localparam int SAMPLE_W = 10;
  localparam int N_PT     = 4;
  localparam int FREQ_W   = 16;
  localparam int IDX_W    = $clog2(N_PT);
  localparam int CNT_W    = $clog2(N_PT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } loader_state_t;

  function automatic logic [IDX_W-1:0] bit_rev(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    for (int b = 0; b < IDX_W; b++) begin
      r[b] = v[IDX_W-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample stream bundle: valid/data from the producer, ready back from the consumer.
interface fft_frame_loader_if import fft_pkg::*; ();

  logic                s_valid;
  logic [SAMPLE_W-1:0] s_data;
  logic                s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/fft_sample_buf.sv
// Back buffer: one sample per accept edge into slot cnt; ready while cnt < N_PT.
// Once full, ready stays low until clr_i empties it on the copy edge.
module fft_sample_buf import fft_pkg::*; (
  input  logic                          clk_in,
  input  logic                          reset,
  fft_frame_loader_if.slave             s_if,
  input  logic                          clr_i,
  output logic                          full_o,
  output logic [N_PT-1:0][SAMPLE_W-1:0] buf_o
);

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [N_PT-1:0][SAMPLE_W-1:0] buf_q, buf_d;
  logic                          accept;

  assign s_if.s_ready = (cnt_q < CNT_W'(N_PT));
  assign accept       = s_if.s_valid && s_if.s_ready;
  assign full_o       = (cnt_q == CNT_W'(N_PT));
  assign buf_o        = buf_q;

  // clr_i only fires when full, so it never collides with an accept
  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (accept) begin
      buf_d[cnt_q[IDX_W-1:0]] = s_if.s_data;
      cnt_d                   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Frame loader: copies a full 4-sample back buffer into pt0..pt3 one edge after it fills, pulses new_t, waits for fft_done.
// Upstream is stalled only while the back buffer is full. FFT_LOADER_FRAME_CNT_EN adds an 8-bit frame_cnt output.
module fft_frame_loader import fft_pkg::*; #(
  parameter bit BITREV = 1'b1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                s_ready,
  input  logic                fft_done,
  output logic                new_t,
  output logic [SAMPLE_W-1:0] pt0,
  output logic [SAMPLE_W-1:0] pt1,
  output logic [SAMPLE_W-1:0] pt2,
  output logic [SAMPLE_W-1:0] pt3,
  output logic                busy
`ifdef FFT_LOADER_FRAME_CNT_EN
  ,
  output logic [7:0]          frame_cnt
`endif
);

  fft_frame_loader_if buf_if ();

  loader_state_t                 state_q, state_d;
  logic [N_PT-1:0][SAMPLE_W-1:0] pt_q, pt_d;
  logic [N_PT-1:0][SAMPLE_W-1:0] back_buf;
  logic                          full;
  logic                          copy;

  assign buf_if.s_valid = s_valid;
  assign buf_if.s_data  = s_data;
  assign s_ready        = buf_if.s_ready;

  fft_sample_buf u_buf (
    .clk_in (clk_in),
    .reset  (reset),
    .s_if   (buf_if),
    .clr_i  (copy),
    .full_o (full),
    .buf_o  (back_buf)
  );

  // fft_done is only looked at in WAIT_DONE; IDLE and ISSUE ignore it
  always_comb begin
    state_d = state_q;
    copy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (full) begin
          copy    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (fft_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    pt_d = pt_q;
    if (copy) begin
      for (int i = 0; i < N_PT; i++) begin
        pt_d[i] = BITREV ? back_buf[bit_rev(IDX_W'(i))] : back_buf[IDX_W'(i)];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q <= IDLE;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
    end
  end

  assign new_t = (state_q == ISSUE);
  assign busy  = (state_q != IDLE);
  assign pt0   = pt_q[0];
  assign pt1   = pt_q[1];
  assign pt2   = pt_q[2];
  assign pt3   = pt_q[3];

`ifdef FFT_LOADER_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = copy ? frame_cnt_q + 8'd1 : frame_cnt_q;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: BITREV=1 and BITREV=0 instances share one stimulus stream.
module tb_fft_frame_loader;
  import fft_pkg::*;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic reset    = 1'b0;
  logic fft_done = 1'b0;
  fft_frame_loader_if sif ();

  logic                s_ready0;
  logic                new_t1, new_t0, busy1, busy0;
  logic [SAMPLE_W-1:0] p1 [4];
  logic [SAMPLE_W-1:0] p0 [4];
`ifdef FFT_LOADER_FRAME_CNT_EN
  logic [7:0] fc1, fc0;
`endif

  fft_frame_loader #(.BITREV(1'b1)) dut1 (
    .clk_in(clk_in), .reset(reset), .s_valid(sif.s_valid), .s_data(sif.s_data),
    .s_ready(sif.s_ready), .fft_done(fft_done), .new_t(new_t1),
    .pt0(p1[0]), .pt1(p1[1]), .pt2(p1[2]), .pt3(p1[3]), .busy(busy1)
`ifdef FFT_LOADER_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  fft_frame_loader #(.BITREV(1'b0)) dut0 (
    .clk_in(clk_in), .reset(reset), .s_valid(sif.s_valid), .s_data(sif.s_data),
    .s_ready(s_ready0), .fft_done(fft_done), .new_t(new_t0),
    .pt0(p0[0]), .pt1(p0[1]), .pt2(p0[2]), .pt3(p0[3]), .busy(busy0)
`ifdef FFT_LOADER_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of accepted samples plus "pulse pending" / "awaiting done" flags.
  logic [SAMPLE_W-1:0] m_q [$];
  bit                  m_pulse, m_wait;
  logic [SAMPLE_W-1:0] m_pt1 [4];
  logic [SAMPLE_W-1:0] m_pt0 [4];
  int                  m_frames;
  int                  br [4] = '{0, 2, 1, 3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit v, input logic [SAMPLE_W-1:0] d, input bit done, input bit rst_n);
    bit copy;
    if (!rst_n) begin
      m_q.delete();
      m_pulse  = 0;
      m_wait   = 0;
      m_frames = 0;
      for (int i = 0; i < 4; i++) begin
        m_pt1[i] = '0;
        m_pt0[i] = '0;
      end
    end else begin
      copy = (m_q.size() == 4) && !m_pulse && !m_wait;
      if (copy) begin
        for (int i = 0; i < 4; i++) begin
          m_pt0[i] = m_q[i];
          m_pt1[i] = m_q[br[i]];
        end
        m_q.delete();
        m_frames = (m_frames + 1) % 256;
      end else if (v && m_q.size() < 4) begin
        m_q.push_back(d);
      end
      m_wait  = m_pulse || (m_wait && !done);
      m_pulse = copy;
    end
  endtask

  task automatic compare_model();
    chk("m_ready1", sif.s_ready, m_q.size() < 4);
    chk("m_ready0", s_ready0, m_q.size() < 4);
    chk("m_new_t1", new_t1, m_pulse);
    chk("m_new_t0", new_t0, m_pulse);
    chk("m_busy1", busy1, m_pulse || m_wait);
    chk("m_busy0", busy0, m_pulse || m_wait);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("m_pt1[%0d]", i), p1[i], m_pt1[i]);
      chk($sformatf("m_pt0[%0d]", i), p0[i], m_pt0[i]);
    end
`ifdef FFT_LOADER_FRAME_CNT_EN
    chk("m_fcnt1", fc1, m_frames);
    chk("m_fcnt0", fc0, m_frames);
`endif
  endtask

  task automatic step(input bit v, input logic [SAMPLE_W-1:0] d, input bit done, input bit rst_n);
    sif.s_valid = v;
    sif.s_data  = d;
    fft_done    = done;
    reset       = rst_n;
    @(posedge clk_in);
    model_edge(v, d, done, rst_n);
    @(negedge clk_in);
    compare_model();
  endtask

  task automatic chk_frame(input string name, input int f0, input int f1, input int f2, input int f3);
    int f [4];
    f = '{f0, f1, f2, f3};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s pt1[%0d]", name, i), p1[i], f[br[i]]);
      chk($sformatf("%s pt0[%0d]", name, i), p0[i], f[i]);
    end
  endtask

  typedef struct {
    bit                  v;
    logic [SAMPLE_W-1:0] d;
    bit                  done;
    bit                  rdy;
    bit                  nt;
    bit                  bsy;
    int                  f [4];
  } vec_t;

  vec_t tv [23];

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = '0;

    // Frame values are listed in arrival order; the BITREV=1 view is derived via br[].
    tv[0]  = '{1, 10, 0, 1, 0, 0, '{0, 0, 0, 0}};
    tv[1]  = '{1,  5, 0, 1, 0, 0, '{0, 0, 0, 0}};
    tv[2]  = '{1,  3, 0, 1, 0, 0, '{0, 0, 0, 0}};
    tv[3]  = '{1,  4, 0, 0, 0, 0, '{0, 0, 0, 0}};
    tv[4]  = '{0,  0, 0, 1, 1, 1, '{10, 5, 3, 4}};
    tv[5]  = '{0,  0, 0, 1, 0, 1, '{10, 5, 3, 4}};
    tv[6]  = '{1,  1, 0, 1, 0, 1, '{10, 5, 3, 4}};
    tv[7]  = '{1,  2, 0, 1, 0, 1, '{10, 5, 3, 4}};
    tv[8]  = '{1,  3, 0, 1, 0, 1, '{10, 5, 3, 4}};
    tv[9]  = '{1,  4, 0, 0, 0, 1, '{10, 5, 3, 4}};
    tv[10] = '{0,  0, 0, 0, 0, 1, '{10, 5, 3, 4}};
    tv[11] = '{0,  0, 1, 0, 0, 0, '{10, 5, 3, 4}};
    tv[12] = '{0,  0, 0, 1, 1, 1, '{1, 2, 3, 4}};
    tv[13] = '{0,  0, 0, 1, 0, 1, '{1, 2, 3, 4}};
    tv[14] = '{0,  0, 1, 1, 0, 0, '{1, 2, 3, 4}};
    tv[15] = '{1,  7, 0, 1, 0, 0, '{1, 2, 3, 4}};
    tv[16] = '{1,  8, 0, 1, 0, 0, '{1, 2, 3, 4}};
    tv[17] = '{1,  9, 0, 1, 0, 0, '{1, 2, 3, 4}};
    tv[18] = '{1,  6, 0, 0, 0, 0, '{1, 2, 3, 4}};
    tv[19] = '{0,  0, 1, 1, 1, 1, '{7, 8, 9, 6}};
    tv[20] = '{0,  0, 1, 1, 0, 1, '{7, 8, 9, 6}};
    tv[21] = '{0,  0, 1, 1, 0, 0, '{7, 8, 9, 6}};
    tv[22] = '{0,  0, 0, 1, 0, 0, '{7, 8, 9, 6}};

    step(0, 0, 0, 0);
    chk("rst ready", sif.s_ready, 1);
    chk("rst new_t", new_t1, 0);
    chk("rst busy", busy1, 0);
    chk_frame("rst", 0, 0, 0, 0);

    for (int k = 0; k < 23; k++) begin
      step(tv[k].v, tv[k].d, tv[k].done, 1);
      chk($sformatf("vec%0d ready1", k), sif.s_ready, tv[k].rdy);
      chk($sformatf("vec%0d ready0", k), s_ready0, tv[k].rdy);
      chk($sformatf("vec%0d new_t", k), new_t1, tv[k].nt);
      chk($sformatf("vec%0d busy", k), busy1, tv[k].bsy);
      chk_frame($sformatf("vec%0d", k), tv[k].f[0], tv[k].f[1], tv[k].f[2], tv[k].f[3]);
    end

    // Reset in the middle of a frame drops the partial samples.
    step(1, 11, 0, 1);
    step(1, 12, 0, 1);
    step(0, 0, 0, 0);
    chk("midrst ready", sif.s_ready, 1);
    chk("midrst new_t", new_t1, 0);
    chk("midrst busy", busy1, 0);
    chk_frame("midrst", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1);
      chk("midrst idle new_t", new_t1, 0);
    end
    step(1, 21, 0, 1);
    step(1, 22, 0, 1);
    step(1, 23, 0, 1);
    step(1, 24, 0, 1);
    chk("clean full ready", sif.s_ready, 0);
    step(0, 0, 0, 1);
    chk("clean new_t", new_t1, 1);
    chk_frame("clean", 21, 22, 23, 24);
    step(0, 0, 0, 1);
    chk("clean issue->wait", new_t1, 0);
    step(0, 0, 1, 1);
    chk("clean done idle", busy1, 0);

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) != 0, SAMPLE_W'($urandom_range(0, 1023)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 199) != 0);
    end

`ifdef FFT_LOADER_FRAME_CNT_EN
    step(0, 0, 0, 0);
    for (int k = 0; k < 257; k++) begin
      for (int s = 0; s < 4; s++) step(1, SAMPLE_W'($urandom_range(0, 1023)), 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 1, 1);
    end
    chk("frame_cnt1 257", fc1, 1);
    chk("frame_cnt0 257", fc0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
